// File: rtl/cvxif_instr_pkg.sv
// rtl/cvxif_instr_pkg.sv - shared opcodes, result record and FSM state type for the coprocessor exec stage
package cvxif_instr_pkg;

  localparam logic [6:0] OpCustom0 = 7'b0001011;
  localparam logic [6:0] OpCustom1 = 7'b0101011;
  localparam logic [6:0] OpCustom2 = 7'b1011011;
  localparam logic [6:0] OpCustom3 = 7'b1111011;

  // Width of the id field carried through the result FIFO
  localparam int unsigned CoproIdWidth = 3;

  typedef struct packed {
    logic [CoproIdWidth-1:0] id;
    logic [4:0]              rd;
    logic [31:0]             data;
    logic                    exc;
  } copro_result_t;

  typedef enum logic {
    StIdle = 1'b0,
    StExec = 1'b1
  } exec_state_e;

  // custom1 is the only opcode that retires without a result entry
  function automatic logic op_writes_back(input logic [6:0] op);
    return op != OpCustom1;
  endfunction

endpackage

// File: rtl/cvxif_result_fifo.sv
// rtl/cvxif_result_fifo.sv - small synchronous result FIFO with registered storage and occupancy count
module cvxif_result_fifo
  import cvxif_instr_pkg::*;
#(
  parameter int unsigned Depth = 4,
  parameter type T = copro_result_t
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  T                       push_data_i,
  input  logic                   pop_i,
  output T                       head_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(Depth):0] count_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  T                mem [Depth];
  logic [PtrW-1:0] wptr_q;
  logic [PtrW-1:0] rptr_q;
  logic [PtrW:0]   cnt_q;
  logic            do_push;
  logic            do_pop;

  assign full_o  = (cnt_q == (PtrW+1)'(Depth));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign head_o  = mem[rptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Storage, pointers and count; storage is cleared so the head reads zero out of reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < int'(Depth); i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wptr_q] <= push_data_i;
        wptr_q      <= wptr_q + 1'b1;
      end
      if (do_pop) begin
        rptr_q <= rptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/cvxif_copro_exec.sv
// rtl/cvxif_copro_exec.sv - coprocessor exec stage; CVXIF_COPRO_MUL_EN builds the custom3 multiplier
module cvxif_copro_exec
  import cvxif_instr_pkg::*;
#(
  parameter int unsigned FifoDepth  = 4,
  parameter int unsigned IdWidth    = CoproIdWidth,
  parameter int unsigned MulLatency = 3
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               issue_valid_i,
  output logic               issue_ready_o,
  input  logic [31:0]        issue_instr_i,
  input  logic [IdWidth-1:0] issue_id_i,
  input  logic [31:0]        issue_rs1_i,
  input  logic [31:0]        issue_rs2_i,
  input  logic               kill_i,
  output logic               result_valid_o,
  input  logic               result_ready_i,
  output logic [IdWidth-1:0] result_id_o,
  output logic [4:0]         result_rd_o,
  output logic [31:0]        result_data_o,
  output logic               result_exc_o,
  output logic               busy_o
);

  localparam int unsigned CntW = $clog2(MulLatency + 1);

  exec_state_e             state_q;
  exec_state_e             state_d;
  logic [CntW-1:0]         cnt_q;
  logic [CntW-1:0]         lat_d;
  logic [IdWidth-1:0]      id_q;
  logic [4:0]              rd_q;
  logic [6:0]              opc_q;
  logic [31:0]             rs1_q;
  logic [31:0]             rs2_q;
  logic                    accept;
  logic                    last_cycle;
  logic                    push;
  logic                    wb;
  copro_result_t           res;
  copro_result_t           head;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [$clog2(FifoDepth):0] fifo_count_unused;
  logic [19:0]             instr_unused;

  assign instr_unused = issue_instr_i[31:12];
  assign accept       = issue_valid_i && issue_ready_o;
  assign last_cycle   = (cnt_q == CntW'(1));

  // Operation latency selected from the incoming opcode
  always_comb begin
    lat_d = CntW'(1);
`ifdef CVXIF_COPRO_MUL_EN
    if (issue_instr_i[6:0] == OpCustom3) begin
      lat_d = CntW'(MulLatency);
    end
`endif
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: a kill or the final counted cycle ends EXEC
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (accept) state_d = StExec;
      StExec: if (kill_i || last_cycle) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs: issue handshake and result push on an unkilled final cycle
  always_comb begin
    issue_ready_o = (state_q == StIdle) && !fifo_full;
    push          = (state_q == StExec) && last_cycle && !kill_i && wb;
  end

  // Operand capture at accept and latency countdown during EXEC
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      id_q  <= '0;
      rd_q  <= '0;
      opc_q <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
    end else if (accept) begin
      cnt_q <= lat_d;
      id_q  <= issue_id_i;
      rd_q  <= issue_instr_i[11:7];
      opc_q <= issue_instr_i[6:0];
      rs1_q <= issue_rs1_i;
      rs2_q <= issue_rs2_i;
    end else if (state_q == StExec) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  // Result computation from the latched operands
  always_comb begin
    res.id   = CoproIdWidth'(id_q);
    res.rd   = rd_q;
    res.data = '0;
    res.exc  = 1'b0;
    wb       = op_writes_back(opc_q);
    case (opc_q)
      OpCustom0: res.data = rs1_q + rs2_q;
      OpCustom1: res.data = '0;
      OpCustom2: res.data = rs1_q - rs2_q;
`ifdef CVXIF_COPRO_MUL_EN
      OpCustom3: res.data = rs1_q * rs2_q;
`else
      OpCustom3: res.exc  = 1'b1;
`endif
      default:   res.exc  = 1'b1;
    endcase
  end

  cvxif_result_fifo #(
    .Depth (FifoDepth),
    .T     (copro_result_t)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (push),
    .push_data_i (res),
    .pop_i       (result_valid_o && result_ready_i),
    .head_o      (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count_unused)
  );

  assign result_valid_o = !fifo_empty;
  assign result_id_o    = IdWidth'(head.id);
  assign result_rd_o    = head.rd;
  assign result_data_o  = head.data;
  assign result_exc_o   = head.exc;
  assign busy_o         = (state_q != StIdle) || !fifo_empty;

endmodule

// File: tb/tb_cvxif_copro_exec.sv
// tb/tb_cvxif_copro_exec.sv - directed self-checking bench for cvxif_copro_exec
module tb_cvxif_copro_exec;

  localparam logic [6:0] C0  = 7'b0001011;
  localparam logic [6:0] C1  = 7'b0101011;
  localparam logic [6:0] C2  = 7'b1011011;
  localparam logic [6:0] C3  = 7'b1111011;
  localparam logic [6:0] ILL = 7'b0110011;

  logic        clk;
  logic        rst_i;
  logic        issue_valid_i;
  logic        issue_ready_o;
  logic [31:0] issue_instr_i;
  logic [2:0]  issue_id_i;
  logic [31:0] issue_rs1_i;
  logic [31:0] issue_rs2_i;
  logic        kill_i;
  logic        result_valid_o;
  logic        result_ready_i;
  logic [2:0]  result_id_o;
  logic [4:0]  result_rd_o;
  logic [31:0] result_data_o;
  logic        result_exc_o;
  logic        busy_o;

  int errors = 0;
  int checks = 0;

  cvxif_copro_exec #(
    .FifoDepth  (4),
    .IdWidth    (3),
    .MulLatency (3)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .issue_valid_i  (issue_valid_i),
    .issue_ready_o  (issue_ready_o),
    .issue_instr_i  (issue_instr_i),
    .issue_id_i     (issue_id_i),
    .issue_rs1_i    (issue_rs1_i),
    .issue_rs2_i    (issue_rs2_i),
    .kill_i         (kill_i),
    .result_valid_o (result_valid_o),
    .result_ready_i (result_ready_i),
    .result_id_o    (result_id_o),
    .result_rd_o    (result_rd_o),
    .result_data_o  (result_data_o),
    .result_exc_o   (result_exc_o),
    .busy_o         (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Present an instruction at a falling edge, hold it until ready, return 1 ns after the accept edge
  task automatic do_issue(input logic [6:0] op, input logic [2:0] id, input logic [4:0] rd,
                          input logic [31:0] a, input logic [31:0] b);
    int n;
    @(negedge clk);
    issue_instr_i = {20'hABCDE, rd, op};
    issue_id_i    = id;
    issue_rs1_i   = a;
    issue_rs2_i   = b;
    issue_valid_i = 1'b1;
    n = 0;
    while (issue_ready_o !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (issue_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL issue_accept: issue_ready_o=%b expected 1", issue_ready_o);
    end
    @(posedge clk);
    #1 issue_valid_i = 1'b0;
  endtask

  task automatic pop_one();
    result_ready_i = 1'b1;
    @(posedge clk);
    #1 result_ready_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (issue_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", issue_ready_o); end
    checks++;
    if (result_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", result_valid_o); end
    checks++;
    if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
    checks++;
    if ({result_id_o, result_rd_o, result_data_o, result_exc_o} !== 41'h0) begin
      errors++;
      $display("FAIL reset_result: got id=%h rd=%h data=%h exc=%b expected all 0",
               result_id_o, result_rd_o, result_data_o, result_exc_o);
    end
    rst_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_alu();
    logic [6:0]  op  [5] = '{C0, C2, C0, ILL, C2};
    logic [31:0] ra  [5] = '{32'h5, 32'h0, 32'h8000_0000, 32'h1, 32'h10};
    logic [31:0] rb  [5] = '{32'h3, 32'h1, 32'h8000_0000, 32'h2, 32'h3};
    logic [2:0]  ids [5] = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
    logic [4:0]  rds [5] = '{5'd7, 5'd1, 5'd31, 5'd9, 5'd2};
    logic [31:0] exd [5] = '{32'h8, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'hD};
    logic        exe [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int v = 0; v < 5; v++) begin
      do_issue(op[v], ids[v], rds[v], ra[v], rb[v]);
      @(negedge clk);
      checks++;
      if (issue_ready_o !== 1'b0 || result_valid_o !== 1'b0) begin
        errors++;
        $display("FAIL alu%0d_exec: ready=%b valid=%b expected 0 0", v, issue_ready_o, result_valid_o);
      end
      @(negedge clk);
      checks++;
      if (result_valid_o !== 1'b1) begin errors++; $display("FAIL alu%0d_valid: got %b expected 1", v, result_valid_o); end
      checks++;
      if (result_data_o !== exd[v]) begin errors++; $display("FAIL alu%0d_data: got %h expected %h", v, result_data_o, exd[v]); end
      checks++;
      if (result_id_o !== ids[v] || result_rd_o !== rds[v]) begin
        errors++;
        $display("FAIL alu%0d_idrd: got id=%0d rd=%0d expected id=%0d rd=%0d", v, result_id_o, result_rd_o, ids[v], rds[v]);
      end
      checks++;
      if (result_exc_o !== exe[v]) begin errors++; $display("FAIL alu%0d_exc: got %b expected %b", v, result_exc_o, exe[v]); end
      pop_one();
      checks++;
      if (result_valid_o !== 1'b0 || busy_o !== 1'b0) begin
        errors++;
        $display("FAIL alu%0d_drain: valid=%b busy=%b expected 0 0", v, result_valid_o, busy_o);
      end
    end
  endtask

  task automatic test_custom1();
    logic seen;
    do_issue(C1, 3'd1, 5'd4, 32'h1, 32'h2);
    @(negedge clk);
    checks++;
    if (issue_ready_o !== 1'b0 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL c1_exec: ready=%b busy=%b expected 0 1", issue_ready_o, busy_o);
    end
    @(negedge clk);
    checks++;
    if (issue_ready_o !== 1'b1 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL c1_done: ready=%b busy=%b expected 1 0", issue_ready_o, busy_o);
    end
    seen = result_valid_o;
    repeat (3) begin
      @(negedge clk);
      seen = seen | result_valid_o;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL c1_no_result: valid seen=%b expected 0", seen); end
  endtask

  task automatic test_custom3();
`ifdef CVXIF_COPRO_MUL_EN
    do_issue(C3, 3'd1, 5'd3, 32'h0001_0000, 32'h0001_0001);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (result_valid_o !== 1'b0) begin errors++; $display("FAIL c3_wait%0d: valid=%b expected 0", c, result_valid_o); end
    end
    @(negedge clk);
    checks++;
    if (result_valid_o !== 1'b1 || result_data_o !== 32'h0001_0000 || result_exc_o !== 1'b0) begin
      errors++;
      $display("FAIL c3_mul: valid=%b data=%h exc=%b expected 1 00010000 0", result_valid_o, result_data_o, result_exc_o);
    end
`else
    do_issue(C3, 3'd1, 5'd3, 32'h0001_0000, 32'h0001_0001);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (result_valid_o !== 1'b1 || result_data_o !== 32'h0 || result_exc_o !== 1'b1) begin
      errors++;
      $display("FAIL c3_nomul: valid=%b data=%h exc=%b expected 1 00000000 1", result_valid_o, result_data_o, result_exc_o);
    end
`endif
    pop_one();
  endtask

  task automatic test_kill();
    do_issue(C0, 3'd2, 5'd6, 32'h7, 32'h7);
    kill_i = 1'b1;
    @(posedge clk);
    #1 kill_i = 1'b0;
    @(negedge clk);
    checks++;
    if (result_valid_o !== 1'b0 || issue_ready_o !== 1'b1 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL kill_last: valid=%b ready=%b busy=%b expected 0 1 0", result_valid_o, issue_ready_o, busy_o);
    end
    kill_i = 1'b1;
    do_issue(C0, 3'd7, 5'd5, 32'h1, 32'h1);
    kill_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (result_valid_o !== 1'b1 || result_data_o !== 32'h2 || result_id_o !== 3'd7) begin
      errors++;
      $display("FAIL kill_idle: valid=%b data=%h id=%0d expected 1 00000002 7", result_valid_o, result_data_o, result_id_o);
    end
    pop_one();
`ifdef CVXIF_COPRO_MUL_EN
    do_issue(C3, 3'd3, 5'd8, 32'h3, 32'h4);
    @(negedge clk);
    @(negedge clk);
    kill_i = 1'b1;
    @(posedge clk);
    #1 kill_i = 1'b0;
    @(negedge clk);
    checks++;
    if (issue_ready_o !== 1'b1 || result_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL kill_c3: ready=%b valid=%b expected 1 0", issue_ready_o, result_valid_o);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (result_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL kill_c3_late: valid=%b busy=%b expected 0 0", result_valid_o, busy_o);
    end
`endif
  endtask

  task automatic test_fifo_full();
    result_ready_i = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      do_issue(C0, 3'(i), 5'(i + 10), 32'(i * 10), 32'(i));
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (issue_ready_o !== 1'b0) begin errors++; $display("FAIL full_ready: got %b expected 0", issue_ready_o); end
    checks++;
    if (result_valid_o !== 1'b1 || result_id_o !== 3'd1 || result_data_o !== 32'd11) begin
      errors++;
      $display("FAIL full_head: valid=%b id=%0d data=%0d expected 1 1 11", result_valid_o, result_id_o, result_data_o);
    end
    pop_one();
    checks++;
    if (issue_ready_o !== 1'b1) begin errors++; $display("FAIL full_ready_back: got %b expected 1", issue_ready_o); end
    for (int k = 2; k <= 4; k++) begin
      checks++;
      if (result_valid_o !== 1'b1 || result_id_o !== 3'(k) || result_data_o !== 32'(11 * k) ||
          result_rd_o !== 5'(k + 10)) begin
        errors++;
        $display("FAIL drain%0d: valid=%b id=%0d rd=%0d data=%0d expected 1 %0d %0d %0d",
                 k, result_valid_o, result_id_o, result_rd_o, result_data_o, k, k + 10, 11 * k);
      end
      pop_one();
    end
    checks++;
    if (result_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL drain_empty: valid=%b busy=%b expected 0 0", result_valid_o, busy_o);
    end
  endtask

  task automatic test_reset_mid();
    result_ready_i = 1'b0;
    do_issue(C0, 3'd1, 5'd1, 32'h1, 32'h1);
    @(negedge clk);
    @(negedge clk);
    do_issue(C2, 3'd2, 5'd2, 32'h9, 32'h1);
    rst_i = 1'b1;
    @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    checks++;
    if (result_valid_o !== 1'b0 || busy_o !== 1'b0 || issue_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid: valid=%b busy=%b ready=%b expected 0 0 1", result_valid_o, busy_o, issue_ready_o);
    end
    checks++;
    if (result_id_o !== 3'd0 || result_data_o !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid_head: id=%0d data=%h expected 0 00000000", result_id_o, result_data_o);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (result_valid_o !== 1'b0) begin errors++; $display("FAIL rst_mid_late: valid=%b expected 0", result_valid_o); end
  endtask

  initial begin
    rst_i          = 1'b1;
    issue_valid_i  = 1'b0;
    issue_instr_i  = '0;
    issue_id_i     = '0;
    issue_rs1_i    = '0;
    issue_rs2_i    = '0;
    kill_i         = 1'b0;
    result_ready_i = 1'b0;
    test_reset();
    test_alu();
    test_custom1();
    test_custom3();
    test_kill();
    test_fifo_full();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cvxif_copro_exec.md
# cvxif_copro_exec

Execution stage of the CV-X-IF example coprocessor, directly downstream of the issue/decode stage that matches custom0–custom3 opcodes. It takes one accepted instruction at a time with its source operands, and computes the result in one cycle, or over a multi-cycle latency for custom3. Results with writeback are buffered in a small FIFO and returned to the core over a valid/ready result channel.

## Interface
- `FifoDepth`, default 4: result FIFO entries, power of two, ≥2.
- `IdWidth`, default 3: instruction id width.
- `MulLatency`, default 3: EXEC cycles for custom3, ≥1.
- `clk_i` in 1: the single clock; all logic is on the rising edge.
- `rst_i` in 1: synchronous, active-high reset.
- `issue_valid_i` in 1: accepted instruction present.
- `issue_ready_o` out 1: stage can take an instruction.
- `issue_instr_i` in 32: raw instruction word.
- `issue_id_i` in IdWidth: instruction id.
- `issue_rs1_i` / `issue_rs2_i` in 32: source operands.
- `kill_i` in 1: abort the in-flight instruction.
- `result_valid_o` out 1: FIFO head valid.
- `result_ready_i` in 1: core takes the result.
- `result_id_o` out IdWidth: id of the head entry.
- `result_rd_o` out 5: destination register, `instr[11:7]`.
- `result_data_o` out 32: result value.
- `result_exc_o` out 1: exception flag.
- `busy_o` out 1: FSM not IDLE, or FIFO non-empty.

## Operation
- FSM states:
  - IDLE: waiting for an instruction.
  - EXEC: operation in progress.
- Accept when `issue_valid_i && issue_ready_o`. `issue_ready_o = (state==IDLE) && (count < FifoDepth)`.
- On accept, latch id, rd, opcode (`instr[6:0]`), rs1 and rs2. Load the cycle counter with the op latency, go to EXEC.
- Opcode behaviour:
  - custom0 (0001011): rd = rs1 + rs2 (mod 2^32), latency 1, writeback.
  - custom1 (0101011): no writeback, latency 1; retired silently, no FIFO push.
  - custom2 (1011011): rd = rs1 − rs2 (mod 2^32), latency 1, writeback.
  - custom3 (1111011): see Configuration.
  - Any other opcode: push an entry with exc=1, data=0, latency 1.
- EXEC: decrement the counter each cycle. In the cycle the counter reaches 1, push the result if writeback, then go to IDLE.
- `kill_i` in EXEC: return to IDLE next cycle, no push. `kill_i` in IDLE is ignored. If `kill_i` is high on the final EXEC cycle, no push occurs.
- FIFO:
  - Pop on `result_valid_o && result_ready_i`.
  - Push and pop in the same cycle leave `count` unchanged.
  - Overflow is impossible: accept requires count < FifoDepth and only one instruction is in flight.
  - Pointers wrap modulo FifoDepth.
- Results return in issue order.

## Timing
- Accept at edge E0. A 1-cycle op pushes at E1, and `result_valid_o` is high after E1. Accept-to-valid: 1 cycle for latency-1 ops, MulLatency cycles for custom3.
- `issue_ready_o` is low throughout EXEC, so back-to-back issue occurs every latency+1 cycles at best.
- `result_*_o` are driven from FIFO storage (registered); no combinational path from `issue_*`.
- Reset values:
  - state=IDLE, count=0, pointers=0.
  - `issue_ready_o`=1, `result_valid_o`=0, `busy_o`=0.
  - `result_id_o`, `result_rd_o`, `result_data_o` and `result_exc_o` = 0.
- Reset mid-EXEC discards the operation and all FIFO contents.

## Configuration
- Macro `CVXIF_COPRO_MUL_EN`.
- Defined: custom3 computes rd = low 32 bits of rs1 × rs2 (unsigned), held MulLatency cycles, writeback, exc=0.
- Undefined: no multiplier is built. custom3 has latency 1 and pushes exc=1, data=0.

## Structure
- Put the following in `cvxif_instr_pkg`:
  - Opcode constants OpCustom0..OpCustom3.
  - Struct `copro_result_t` {id, rd, data, exc}.
- Sub-module `cvxif_result_fifo`: parameterized by FifoDepth and `copro_result_t`; synchronous flops; full/empty/count outputs.

## Test plan
- Reset, then custom0 with rs1=0x0000_0005, rs2=0x0000_0003, id=2, rd=7 → one cycle after accept: `result_valid_o`=1, data=0x8, id=2, rd=7, exc=0.
- custom2 with rs1=0, rs2=1 → data=0xFFFF_FFFF (wrap); custom0 with rs1=rs2=0x8000_0000 → data=0.
- custom1 → `issue_ready_o` returns high after 1 cycle, `result_valid_o` never asserts, `busy_o` drops.
- `result_ready_i`=0, issue FifoDepth custom0 ops → FIFO full, `issue_ready_o`=0. Pull `result_ready_i` high for 1 cycle → ready returns, and results drain in id order.
- With `CVXIF_COPRO_MUL_EN` and MulLatency=3, custom3 with rs1=0x10000, rs2=0x10001 → data=0x0001_0000 after 3 cycles. Without the macro → exc=1, data=0 after 1 cycle.
- custom3 accepted, `kill_i` pulsed in cycle 2 → no result, `issue_ready_o`=1 next cycle. `rst_i` during a non-empty FIFO → `result_valid_o`=0 next cycle.
